// File: rtl/mult_issue_sched_pkg.sv
// Shared types for the multiply issue scheduler: FU payload, FSM state and pointer sizing.
package mult_issue_sched_pkg;

  typedef struct packed {
    logic [3:0]  rob_idx;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } issue_fu_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } mult_sched_state_t;

  // A single requester still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_issue_sched_if.sv
// Requester / FU / CDB handshake bundle seen by the multiply issue scheduler.
interface mult_issue_sched_if #(
  parameter int unsigned NumReq = 4
);
  import mult_issue_sched_pkg::*;

  logic           [NumReq-1:0] req_valid;
  issue_fu_data_t [NumReq-1:0] req_data;
  logic           [NumReq-1:0] req_grant;
  logic                        fu_start;
  issue_fu_data_t              fu_data;
  logic                        fu_busy;
  logic                        fu_done;
  logic                        cdb_req;
  logic                        cdb_gnt;
  logic                        fu_cdb_ack;

  modport master (
    input  req_valid, req_data, fu_busy, fu_done, cdb_gnt,
    output req_grant, fu_start, fu_data, cdb_req, fu_cdb_ack
  );

  modport slave (
    output req_valid, req_data, fu_busy, fu_done, cdb_gnt,
    input  req_grant, fu_start, fu_data, cdb_req, fu_cdb_ack
  );

endinterface

// File: rtl/mult_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i, ascending, wrapping at N-1.
module rr_arbiter
  import mult_issue_sched_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = ptr_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_i) + off;
      // Explicit wrap so non-power-of-2 N never indexes past the last requester.
      if (cand >= N) cand = cand - N;
      if (!valid_o && req_i[W'(cand)]) begin
        valid_o          = 1'b1;
        gnt_o[W'(cand)]  = 1'b1;
        idx_o            = W'(cand);
      end
    end
  end

endmodule

// File: rtl/mult_issue_sched.sv
// Issue scheduler for the multi-cycle multiply FU: round-robin issue, CDB writeback, flush.
// Optional perf counters enabled by defining MULT_ISSUE_SCHED_PERF_EN.
module mult_issue_sched
  import mult_issue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 branch_mispredict,
  mult_issue_sched_if.master   bus
`ifdef MULT_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  mult_sched_state_t state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PtrW-1:0]    arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    bus.req_grant  = '0;
    bus.fu_start   = 1'b0;
    bus.fu_data    = 'x;
    bus.cdb_req    = 1'b0;
    bus.fu_cdb_ack = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid && !bus.fu_busy && !branch_mispredict) begin
          bus.req_grant = arb_gnt;
          bus.fu_start  = 1'b1;
          bus.fu_data   = bus.req_data[arb_idx];
          rr_ptr_d      = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (bus.fu_done) state_d = StExec == StExec ? StWb : StExec;
      end
      StWb: begin
        bus.cdb_req = 1'b1;
        if (bus.cdb_gnt) begin
          bus.fu_cdb_ack = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over done/gnt; the round-robin pointer is deliberately kept.
    if (branch_mispredict) begin
      state_d        = StIdle;
      bus.fu_cdb_ack = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef MULT_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.fu_start) perf_issue_q <= perf_issue_q + 32'd1;
      if (|bus.req_valid && !(|bus.req_grant)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  // A completion outside EXEC means the FU and scheduler disagree about ownership.
  fu_done_only_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
    bus.fu_done |-> (state_q == StExec));

endmodule

// File: tb/tb_mult_issue_sched.sv
// Directed bench for mult_issue_sched: 4-requester and 3-requester instances, issue scoreboard.
module tb_mult_issue_sched;
  import mult_issue_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic bm4, bm3;

  always #5 clk = ~clk;

  mult_issue_sched_if #(.NumReq(4)) bus4 ();
  mult_issue_sched_if #(.NumReq(3)) bus3 ();

`ifdef MULT_ISSUE_SCHED_PERF_EN
  logic [31:0] pi4, ps4, pi3, ps3;
  logic [31:0] stall_base;
`endif

  mult_issue_sched #(.NUM_REQ(4)) dut4 (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_mispredict (bm4),
    .bus               (bus4.master)
`ifdef MULT_ISSUE_SCHED_PERF_EN
    ,
    .perf_issue_cnt    (pi4),
    .perf_stall_cnt    (ps4)
`endif
  );

  mult_issue_sched #(.NUM_REQ(3)) dut3 (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_mispredict (bm3),
    .bus               (bus3.master)
`ifdef MULT_ISSUE_SCHED_PERF_EN
    ,
    .perf_issue_cnt    (pi3),
    .perf_stall_cnt    (ps3)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int model_ptr;
  int n_issued;
  logic [3:0]     exp_gnt_q[$];
  issue_fu_data_t exp_data_q[$];

  function automatic issue_fu_data_t mk_data(input int i);
    issue_fu_data_t d;
    d.rob_idx = 4'(i + 5);
    d.funct3  = 3'(i);
    d.rs1_val = 32'h1000_0000 + 32'(i);
    d.rs2_val = 32'hA5A5_0000 ^ 32'(i * 7);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin choice for the 4-requester instance.
  task automatic push_expect(input logic [3:0] v);
    int k;
    k = -1;
    for (int off = 0; off < 4; off++) begin
      int c;
      c = (model_ptr + off) % 4;
      if (k < 0 && v[c]) k = c;
    end
    if (k >= 0) begin
      exp_gnt_q.push_back(4'(1 << k));
      exp_data_q.push_back(mk_data(k));
      model_ptr = (k + 1) % 4;
      n_issued++;
    end
  endtask

  task automatic check_issue(input string tag);
    logic [3:0]     eg;
    issue_fu_data_t ed;
    chk({tag, "_fu_start"}, bus4.fu_start, 1'b1);
    chk({tag, "_sb_nonempty"}, exp_gnt_q.size() != 0, 1'b1);
    if (exp_gnt_q.size() != 0) begin
      eg = exp_gnt_q.pop_front();
      ed = exp_data_q.pop_front();
      chk({tag, "_grant"}, bus4.req_grant, eg);
      chk({tag, "_fu_data"}, bus4.fu_data, ed);
    end
  endtask

  // Drive the FU through EXEC and WB after an issue cycle; returns in IDLE at edge+1.
  task automatic finish_op(input int lat, input int gnt_wait, input logic [3:0] rem);
    tick();
    bus4.req_valid = rem;
    bus4.fu_busy   = 1'b1;
    #1;
    chk("exec_no_grant", bus4.req_grant, 4'b0000);
    chk("exec_no_start", bus4.fu_start, 1'b0);
    chk("exec_no_cdb_req", bus4.cdb_req, 1'b0);
    for (int i = 1; i < lat; i++) begin
      tick();
      #1;
      chk("exec_wait_grant", bus4.req_grant, 4'b0000);
      chk("exec_wait_cdb_req", bus4.cdb_req, 1'b0);
    end
    tick();
    bus4.fu_done = 1'b1;
    #1;
    chk("exec_done_cdb_req", bus4.cdb_req, 1'b0);
    tick();
    bus4.fu_done = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      #1;
      chk("wb_hold_cdb_req", bus4.cdb_req, 1'b1);
      chk("wb_hold_no_ack", bus4.fu_cdb_ack, 1'b0);
      chk("wb_hold_no_grant", bus4.req_grant, 4'b0000);
      tick();
    end
    bus4.cdb_gnt = 1'b1;
    #1;
    chk("wb_gnt_cdb_req", bus4.cdb_req, 1'b1);
    chk("wb_gnt_ack", bus4.fu_cdb_ack, 1'b1);
    tick();
    bus4.cdb_gnt = 1'b0;
    bus4.fu_busy = 1'b0;
  endtask

  task automatic op3();
    tick();
    bus3.fu_busy = 1'b1;
    tick();
    bus3.fu_done = 1'b1;
    tick();
    bus3.fu_done = 1'b0;
    bus3.cdb_gnt = 1'b1;
    #1;
    chk("n3_ack", bus3.fu_cdb_ack, 1'b1);
    tick();
    bus3.cdb_gnt = 1'b0;
    bus3.fu_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bm4       = 1'b0;
    bm3       = 1'b0;
    model_ptr = 0;
    n_issued  = 0;
    bus4.req_valid = '0;
    bus4.fu_busy   = 1'b0;
    bus4.fu_done   = 1'b0;
    bus4.cdb_gnt   = 1'b0;
    for (int i = 0; i < 4; i++) bus4.req_data[i] = mk_data(i);
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.fu_busy   = 1'b0;
    bus3.fu_done   = 1'b0;
    bus3.cdb_gnt   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", bus4.req_grant, 4'b0000);
    chk("rst_fu_start", bus4.fu_start, 1'b0);
    chk("rst_cdb_req", bus4.cdb_req, 1'b0);
    chk("rst_ack", bus4.fu_cdb_ack, 1'b0);
    rst_n = 1'b1;
    tick();

    // First issue from reset goes to requester 0.
    bus4.req_valid = 4'b1111;
    push_expect(4'b1111);
    #1;
    check_issue("t1");
    chk("t1_first_grant", bus4.req_grant, 4'b0001);
    finish_op(2, 0, 4'b1110);

    push_expect(4'b1110);
    #1;
    check_issue("t2");
    chk("t2_rr_next", bus4.req_grant, 4'b0010);
    // CDB withholds grant for 5 cycles; issue must follow the ack cycle immediately.
    finish_op(1, 5, 4'b1100);

    push_expect(4'b1100);
    #1;
    check_issue("t3");
    chk("t3_after_stall", bus4.req_grant, 4'b0100);

    // Mispredict coincident with fu_done in EXEC.
    tick();
    bus4.req_valid = 4'b1000;
    bus4.fu_busy   = 1'b1;
    #1;
    chk("mp_exec_grant", bus4.req_grant, 4'b0000);
    tick();
    bus4.fu_done = 1'b1;
    bm4          = 1'b1;
    #1;
    chk("mp_exec_cdb_req", bus4.cdb_req, 1'b0);
    tick();
    bus4.fu_done   = 1'b0;
    bus4.fu_busy   = 1'b0;
    bus4.req_valid = 4'b1001;
    #1;
    chk("mp_idle_cdb_req", bus4.cdb_req, 1'b0);
    chk("mp_idle_grant", bus4.req_grant, 4'b0000);
    chk("mp_idle_start", bus4.fu_start, 1'b0);
    tick();
    bm4 = 1'b0;
    push_expect(4'b1001);
    #1;
    check_issue("t4");
    chk("t4_ptr_kept", bus4.req_grant, 4'b1000);
    finish_op(1, 0, 4'b0001);

    // FU busy blocks issue while in IDLE.
    bus4.fu_busy = 1'b1;
`ifdef MULT_ISSUE_SCHED_PERF_EN
    stall_base = ps4;
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_no_grant", bus4.req_grant, 4'b0000);
      chk("busy_no_start", bus4.fu_start, 1'b0);
      tick();
    end
`ifdef MULT_ISSUE_SCHED_PERF_EN
    chk("perf_stall_delta", ps4, stall_base + 32'd3);
`endif
    bus4.fu_busy = 1'b0;
    push_expect(4'b0001);
    #1;
    check_issue("t5");
    chk("t5_wrap_to_0", bus4.req_grant, 4'b0001);
`ifdef MULT_ISSUE_SCHED_PERF_EN
    chk("perf_issue_cnt", pi4, 32'(n_issued - 1));
`endif

    // Asynchronous reset while in WB.
    tick();
    bus4.req_valid = 4'b0000;
    bus4.fu_busy   = 1'b1;
    tick();
    bus4.fu_done = 1'b1;
    tick();
    bus4.fu_done = 1'b0;
    #1;
    chk("wb_before_rst", bus4.cdb_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cdb_req", bus4.cdb_req, 1'b0);
    model_ptr = 0;
    tick();
    bus4.fu_busy = 1'b0;
    rst_n        = 1'b1;
    tick();
    bus4.req_valid = 4'b0110;
    push_expect(4'b0110);
    #1;
    check_issue("t6");
    chk("t6_ptr_reset", bus4.req_grant, 4'b0010);
    finish_op(1, 0, 4'b0000);
    chk("sb_drained", exp_gnt_q.size(), 0);

    // Three requesters: pointer wraps from 2 back to 0.
    bus3.req_valid = 3'b011;
    #1;
    chk("n3_g0", bus3.req_grant, 3'b001);
    op3();
    #1;
    chk("n3_g1", bus3.req_grant, 3'b010);
    op3();
    #1;
    chk("n3_wrap", bus3.req_grant, 3'b001);
    op3();
    #1;
    chk("n3_after_wrap", bus3.req_grant, 3'b010);
    op3();
    bus3.req_valid = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
